de10nano_user_io_ctrl: RTL and testbench

//   Parametrised FPGA user-I/O and HPS reset-request controller between board pins, PIO cores and HPS F2H ports.
//   - Debounces N pushbuttons and M DIP switches; latches per-button press events.
//   - Drives LEDs in direct, blink or PWM mode.
//   - Turns level reset requests into fixed-width, prioritised active-low HPS reset pulses.
//   - Packs the STM hardware-event vector.

---
 rtl/de10nano_user_io_pkg.sv | 24 ++
 rtl/de10nano_user_io_ctrl_if.sv | 36 +++
 rtl/io_debounce.sv | 45 ++++
 rtl/de10nano_user_io_ctrl.sv | 174 +++++++++++++++++
 tb/tb_de10nano_user_io_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/de10nano_user_io_pkg.sv
// Shared encodings and helpers for the DE10-Nano user-I/O and HPS reset-request controller.
package de10nano_user_io_pkg;

    localparam logic [1:0] LED_DIRECT = 2'b00;
    localparam logic [1:0] LED_BLINK  = 2'b01;
    localparam logic [1:0] LED_PWM    = 2'b10;
    localparam logic [1:0] LED_OFF    = 2'b11;

    localparam int unsigned RST_REQ_W = 3;
    localparam int unsigned RST_COLD  = 0;
    localparam int unsigned RST_WARM  = 1;
    localparam int unsigned RST_DEBUG = 2;

    typedef enum logic [0:0] {
        SEQ_IDLE  = 1'b0,
        SEQ_PULSE = 1'b1
    } seq_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/de10nano_user_io_ctrl_if.sv
// Pin/PIO/F2H signal bundle between the user-I/O controller and its surroundings.
interface de10nano_user_io_ctrl_if #(
    parameter int unsigned NUM_PB    = 1,
    parameter int unsigned NUM_SW    = 2,
    parameter int unsigned NUM_LED   = 2,
    parameter int unsigned PWM_BITS  = 8,
    parameter int unsigned STM_WIDTH = 28
);
    logic [NUM_PB-1:0]    pb_n_in;
    logic [NUM_SW-1:0]    sw_in;
    logic [NUM_PB-1:0]    pb_db;
    logic [NUM_SW-1:0]    sw_db;
    logic [NUM_PB-1:0]    pb_event;
    logic [NUM_PB-1:0]    pb_event_clr;
    logic [NUM_LED-1:0]   led_value;
    logic [2*NUM_LED-1:0] led_mode;
    logic [PWM_BITS-1:0]  led_duty;
    logic [NUM_LED-1:0]   user_led;
    logic [2:0]           rst_req;
    logic                 f2h_cold_reset_n;
    logic                 f2h_warm_reset_n;
    logic                 f2h_debug_reset_n;
    logic [STM_WIDTH-1:0] stm_hw_events;

    modport master (
        output pb_n_in, sw_in, pb_event_clr, led_value, led_mode, led_duty, rst_req,
        input  pb_db, sw_db, pb_event, user_led,
        input  f2h_cold_reset_n, f2h_warm_reset_n, f2h_debug_reset_n, stm_hw_events
    );

    modport slave (
        input  pb_n_in, sw_in, pb_event_clr, led_value, led_mode, led_duty, rst_req,
        output pb_db, sw_db, pb_event, user_led,
        output f2h_cold_reset_n, f2h_warm_reset_n, f2h_debug_reset_n, stm_hw_events
    );
endinterface

// File: rtl/io_debounce.sv
// One input channel: 2-flop synchroniser followed by a stable-count debouncer.
// Works in raw pin polarity; RESET_VAL is the idle level of the pin.
module io_debounce
    import de10nano_user_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter logic        RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable
);
    localparam int unsigned      CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= RESET_VAL;
            sync2 <= RESET_VAL;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Any cycle agreeing with the stable state restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable <= RESET_VAL;
            cnt    <= '0;
        end else if (sync2 == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            stable <= sync2;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/de10nano_user_io_ctrl.sv
// DE10-Nano user I/O: debounced buttons/switches, LED direct/blink/PWM drive,
// prioritised fixed-width HPS reset-request pulses and STM event packing.
module de10nano_user_io_ctrl
    import de10nano_user_io_pkg::*;
#(
    parameter int unsigned NUM_PB           = 1,
    parameter int unsigned NUM_SW           = 2,
    parameter int unsigned NUM_LED          = 2,
    parameter int unsigned DEBOUNCE_CYCLES  = 50000,
    parameter int unsigned BLINK_CYCLES     = 12500000,
    parameter int unsigned PWM_BITS         = 8,
    parameter int unsigned RST_PULSE_CYCLES = 16,
    parameter int unsigned STM_WIDTH        = 28
) (
    input logic                    sys_clk,
    input logic                    sys_reset,
    de10nano_user_io_ctrl_if.slave io
);
    localparam int unsigned        BLINK_W    = cnt_width(BLINK_CYCLES);
    localparam int unsigned        PULSE_W    = cnt_width(RST_PULSE_CYCLES);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);
    localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(RST_PULSE_CYCLES - 1);
    localparam logic [0:0]         ST_IDLE    = 1'(SEQ_IDLE);
    localparam logic [0:0]         ST_PULSE   = 1'(SEQ_PULSE);

    logic [NUM_PB-1:0]    pb_stable_n;
    logic [NUM_PB-1:0]    pb_db;
    logic [NUM_PB-1:0]    pb_db_q;
    logic [NUM_PB-1:0]    pb_event;
    logic [NUM_SW-1:0]    sw_db;
    logic [BLINK_W-1:0]   blink_cnt;
    logic                 blink_phase;
    logic [PWM_BITS-1:0]  pwm_cnt;
    logic                 pwm_on_c;
    logic [NUM_LED-1:0]   led_next;
    logic [NUM_LED-1:0]   user_led;
    logic [RST_REQ_W-1:0] req_s1;
    logic [RST_REQ_W-1:0] req_s2;
    logic [RST_REQ_W-1:0] req_q;
    logic [RST_REQ_W-1:0] req_rise_c;
    logic [0:0]           state;
    logic [0:0]           state_next;
    logic [RST_REQ_W-1:0] target;
    logic [RST_REQ_W-1:0] target_next;
    logic [PULSE_W-1:0]   pulse_cnt;
    logic [PULSE_W-1:0]   pulse_cnt_next;
    logic [RST_REQ_W-1:0] f2h_n;

    for (genvar i = 0; i < NUM_PB; i++) begin : g_pb
        io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b1)) u_db (
            .clk(sys_clk), .rst(sys_reset), .raw(io.pb_n_in[i]), .stable(pb_stable_n[i])
        );
    end

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b0)) u_db (
            .clk(sys_clk), .rst(sys_reset), .raw(io.sw_in[i]), .stable(sw_db[i])
        );
    end

    assign pb_db = ~pb_stable_n;

    // Sticky press events; a new press in the clearing cycle wins.
    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            pb_db_q  <= '0;
            pb_event <= '0;
        end else begin
            pb_db_q  <= pb_db;
            pb_event <= (pb_event & ~io.pb_event_clr) | (pb_db & ~pb_db_q);
        end
    end

    assign pwm_on_c = (pwm_cnt < io.led_duty);

    always_comb begin
        led_next = '0;
        for (int i = 0; i < int'(NUM_LED); i++) begin
            case (io.led_mode[2*i +: 2])
                LED_DIRECT: led_next[i] = io.led_value[i];
                LED_BLINK:  led_next[i] = blink_phase;
                LED_PWM:    led_next[i] = pwm_on_c;
                default:    led_next[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            pwm_cnt     <= '0;
            user_led    <= '0;
        end else begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end
            pwm_cnt  <= pwm_cnt + PWM_BITS'(1);
            user_led <= led_next;
        end
    end

    // Edge detector history resets to 0 so a request held through reset fires once.
    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            req_s1 <= '0;
            req_s2 <= '0;
            req_q  <= '0;
        end else begin
            req_s1 <= io.rst_req;
            req_s2 <= req_s1;
            req_q  <= req_s2;
        end
    end

    assign req_rise_c = req_s2 & ~req_q;

    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            state     <= ST_IDLE;
            target    <= '0;
            pulse_cnt <= '0;
        end else begin
            state     <= state_next;
            target    <= target_next;
            pulse_cnt <= pulse_cnt_next;
        end
    end

    // Edges seen while a pulse is running are dropped, not queued.
    always_comb begin
        state_next     = state;
        target_next    = target;
        pulse_cnt_next = pulse_cnt;
        case (state)
            ST_IDLE: begin
                if (|req_rise_c) begin
                    state_next     = ST_PULSE;
                    pulse_cnt_next = '0;
                    target_next    = '0;
                    if (req_rise_c[RST_COLD])      target_next[RST_COLD]  = 1'b1;
                    else if (req_rise_c[RST_WARM]) target_next[RST_WARM]  = 1'b1;
                    else                           target_next[RST_DEBUG] = 1'b1;
                end
            end
            ST_PULSE: begin
                if (pulse_cnt == PULSE_LAST) begin
                    state_next     = ST_IDLE;
                    pulse_cnt_next = '0;
                end else begin
                    pulse_cnt_next = pulse_cnt + PULSE_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) f2h_n <= '1;
        else           f2h_n <= (state_next == ST_PULSE) ? ~target_next : '1;
    end

    assign io.pb_db             = pb_db;
    assign io.sw_db             = sw_db;
    assign io.pb_event          = pb_event;
    assign io.user_led          = user_led;
    assign io.f2h_cold_reset_n  = f2h_n[RST_COLD];
    assign io.f2h_warm_reset_n  = f2h_n[RST_WARM];
    assign io.f2h_debug_reset_n = f2h_n[RST_DEBUG];
    assign io.stm_hw_events     = STM_WIDTH'({sw_db, user_led, pb_db});
endmodule

// File: tb/tb_de10nano_user_io_ctrl.sv
// Scoreboard bench for de10nano_user_io_ctrl: stimulus queues time-stamped
// expectations, a negedge monitor pops and compares them when they fall due.
module tb_de10nano_user_io_ctrl;
    import de10nano_user_io_pkg::*;

    localparam int ID_PB_DB  = 0;
    localparam int ID_SW_DB  = 1;
    localparam int ID_PB_EVT = 2;
    localparam int ID_LED    = 3;
    localparam int ID_F2H    = 4;
    localparam int ID_STM    = 5;

    typedef struct {
        int          cyc;
        int          id;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   rel0 = 0;
    bit   flush = 1'b0;
    exp_t sb[$];

    de10nano_user_io_ctrl_if #(.NUM_PB(1), .NUM_SW(2), .NUM_LED(2), .PWM_BITS(3), .STM_WIDTH(28)) bus ();

    de10nano_user_io_ctrl #(
        .NUM_PB(1), .NUM_SW(2), .NUM_LED(2), .DEBOUNCE_CYCLES(4), .BLINK_CYCLES(3),
        .PWM_BITS(3), .RST_PULSE_CYCLES(5), .STM_WIDTH(28)
    ) u_dut (
        .sys_clk(clk),
        .sys_reset(rst),
        .io(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] get_sig(input int id);
        case (id)
            ID_PB_DB:  return 32'(bus.pb_db);
            ID_SW_DB:  return 32'(bus.sw_db);
            ID_PB_EVT: return 32'(bus.pb_event);
            ID_LED:    return 32'(bus.user_led);
            ID_F2H:    return 32'({bus.f2h_debug_reset_n, bus.f2h_warm_reset_n, bus.f2h_cold_reset_n});
            default:   return 32'(bus.stm_hw_events);
        endcase
    endfunction

    function automatic string sig_name(input int id);
        case (id)
            ID_PB_DB:  return "pb_db";
            ID_SW_DB:  return "sw_db";
            ID_PB_EVT: return "pb_event";
            ID_LED:    return "user_led";
            ID_F2H:    return "f2h_n{dbg,warm,cold}";
            default:   return "stm_hw_events";
        endcase
    endfunction

    // Monitor: compare every expectation due this cycle; leftovers at flush are misses.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc || flush) begin
                logic [31:0] act;
                act = get_sig(sb[i].id);
                checks++;
                if (sb[i].cyc != cyc || act !== sb[i].val) begin
                    failures++;
                    $display("FAIL %s due_cyc=%0d now=%0d actual=0x%0h expected=0x%0h",
                             sig_name(sb[i].id), sb[i].cyc, cyc, act, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    task automatic expect_at(input int dcyc, input int id, input logic [31:0] val);
        exp_t e;
        e.cyc = cyc + dcyc;
        e.id  = id;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic expect_f2h(input int from, input int to, input logic [2:0] v);
        for (int d = from; d <= to; d++) expect_at(d, ID_F2H, 32'(v));
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference LED waveforms, counted from the first clock edge after reset release.
    function automatic logic pwm_bit(input int k, input int duty);
        return ((k - 1 - rel0) % 8) < duty;
    endfunction

    function automatic logic blink_bit(input int k);
        return (((k - 1 - rel0) / 3) % 2) == 1;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pb_n_in      = 1'b1;
        bus.sw_in        = 2'b00;
        bus.pb_event_clr = 1'b0;
        bus.led_value    = 2'b00;
        bus.led_mode     = {LED_OFF, LED_OFF};
        bus.led_duty     = 3'd0;
        bus.rst_req      = 3'b000;

        // Reset values while reset is held
        step(1);
        checks++;
        if (bus.pb_db !== 1'b0 || bus.sw_db !== 2'b00 || bus.pb_event !== 1'b0 ||
            bus.user_led !== 2'b00 || bus.stm_hw_events !== 28'd0 ||
            {bus.f2h_debug_reset_n, bus.f2h_warm_reset_n, bus.f2h_cold_reset_n} !== 3'b111) begin
            failures++;
            $display("FAIL reset values at cyc=%0d", cyc);
        end
        expect_at(1, ID_PB_DB, 0);
        expect_at(1, ID_SW_DB, 0);
        expect_at(1, ID_PB_EVT, 0);
        expect_at(1, ID_LED, 0);
        expect_at(1, ID_F2H, 32'h7);
        expect_at(1, ID_STM, 0);
        step(2);
        rst  = 1'b0;
        rel0 = cyc;
        step(3);

        // Pushbutton press, event latch, clear, release
        bus.pb_n_in = 1'b0;
        expect_at(5, ID_PB_DB, 0);
        expect_at(6, ID_PB_DB, 1);
        expect_at(6, ID_PB_EVT, 0);
        expect_at(6, ID_STM, 32'h1);
        expect_at(7, ID_PB_EVT, 1);
        expect_at(9, ID_PB_EVT, 1);
        step(10);
        bus.pb_event_clr = 1'b1;
        expect_at(1, ID_PB_EVT, 0);
        step(1);
        bus.pb_event_clr = 1'b0;
        checks++;
        if (bus.pb_event !== 1'b0) begin
            failures++;
            $display("FAIL pb_event not cleared at cyc=%0d actual=%0b", cyc, bus.pb_event);
        end
        expect_at(3, ID_PB_EVT, 0);
        step(3);
        bus.pb_n_in = 1'b1;
        expect_at(5, ID_PB_DB, 1);
        expect_at(6, ID_PB_DB, 0);
        expect_at(8, ID_PB_EVT, 0);
        step(10);

        // Switch glitch rejected, then a clean change accepted
        bus.sw_in[1] = 1'b1;
        step(3);
        bus.sw_in[1] = 1'b0;
        for (int d = 1; d <= 8; d++) expect_at(d, ID_SW_DB, 0);
        step(8);
        bus.sw_in[1] = 1'b1;
        expect_at(5, ID_SW_DB, 0);
        expect_at(6, ID_SW_DB, 32'h2);
        expect_at(6, ID_STM, 32'h10);
        step(10);

        // LED0 PWM at three duties with LED1 direct, then blink, direct, off
        bus.led_value = 2'b10;
        bus.led_mode  = {LED_DIRECT, LED_PWM};
        for (int duty = 0; duty < 3; duty++) begin
            int dv;
            dv = (duty == 0) ? 3 : (duty == 1) ? 0 : 7;
            bus.led_duty = 3'(dv);
            for (int d = 1; d <= 16; d++) expect_at(d, ID_LED, 32'({1'b1, pwm_bit(cyc + d, dv)}));
            step(16);
        end
        bus.led_mode = {LED_BLINK, LED_BLINK};
        for (int d = 1; d <= 12; d++) expect_at(d, ID_LED, 32'({2{blink_bit(cyc + d)}}));
        step(12);
        bus.led_mode  = {LED_DIRECT, LED_DIRECT};
        bus.led_value = 2'b01;
        expect_at(1, ID_LED, 32'h1);
        step(2);
        bus.led_mode = {LED_OFF, LED_OFF};
        expect_at(1, ID_LED, 0);
        expect_at(2, ID_LED, 0);
        step(3);

        // Simultaneous cold+warm: cold wins; debug edge mid-pulse dropped
        bus.rst_req = 3'b011;
        expect_f2h(1, 2, 3'b111);
        expect_f2h(3, 7, 3'b110);
        expect_f2h(8, 20, 3'b111);
        step(4);
        bus.rst_req = 3'b111;
        step(16);
        bus.rst_req = 3'b000;
        expect_f2h(1, 6, 3'b111);
        step(6);

        // Held warm request gives one pulse; re-rise gives another
        bus.rst_req = 3'b010;
        expect_f2h(1, 2, 3'b111);
        expect_f2h(3, 7, 3'b101);
        expect_f2h(8, 40, 3'b111);
        step(40);
        bus.rst_req = 3'b000;
        expect_f2h(1, 5, 3'b111);
        step(5);
        bus.rst_req = 3'b010;
        expect_f2h(1, 2, 3'b111);
        expect_f2h(3, 7, 3'b101);
        expect_f2h(8, 10, 3'b111);
        step(10);
        bus.rst_req = 3'b000;
        step(4);

        // Reset in the middle of a cold pulse, request held through release
        bus.led_mode  = {LED_DIRECT, LED_DIRECT};
        bus.led_value = 2'b11;
        expect_at(1, ID_LED, 32'h3);
        step(2);
        bus.rst_req = 3'b001;
        expect_f2h(1, 2, 3'b111);
        expect_at(3, ID_F2H, 32'h6);
        expect_at(4, ID_F2H, 32'h7);
        expect_at(4, ID_LED, 0);
        expect_at(4, ID_SW_DB, 0);
        expect_at(4, ID_PB_DB, 0);
        expect_at(4, ID_STM, 0);
        step(3);
        checks++;
        if ({bus.f2h_debug_reset_n, bus.f2h_warm_reset_n, bus.f2h_cold_reset_n} !== 3'b110) begin
            failures++;
            $display("FAIL cold pulse not active at cyc=%0d", cyc);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({bus.f2h_debug_reset_n, bus.f2h_warm_reset_n, bus.f2h_cold_reset_n} !== 3'b111 ||
            bus.user_led !== 2'b00 || bus.pb_db !== 1'b0 || bus.sw_db !== 2'b00 ||
            bus.stm_hw_events !== 28'd0) begin
            failures++;
            $display("FAIL async reset did not clear outputs at cyc=%0d", cyc);
        end
        @(negedge clk);
        expect_f2h(1, 2, 3'b111);
        step(2);
        rst = 1'b0;
        expect_f2h(1, 2, 3'b111);
        expect_f2h(3, 7, 3'b110);
        expect_f2h(8, 15, 3'b111);
        step(15);
        bus.rst_req = 3'b000;
        step(3);

        flush = 1'b1;
        step(1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
